// File: rtl/plot_write_receiver.sv
// Pixel-plot receiver: buffers plots in a FIFO, clips them to the screen, writes y*160+x into the framebuffer.
// Optional full-screen clear sweep when CLEAR_SCREEN_EN is defined. States: IDLE=write stage empty | WRITE=mem_we up | CLEAR=sweep.
module plot_write_receiver #(
    parameter int FIFO_DEPTH = 4,
    parameter int SCREEN_W   = 160,
    parameter int SCREEN_H   = 120
`ifdef CLEAR_SCREEN_EN
    ,
    parameter logic [2:0] CLEAR_COLOUR = 3'b000
`endif
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  x_in,
    input  logic [6:0]  y_in,
    input  logic [2:0]  colour_in,
    input  logic        plot_in,
    output logic        ready_out,
    output logic [14:0] mem_addr,
    output logic [2:0]  mem_data,
    output logic        mem_we,
    input  logic        mem_busy,
    output logic [2:0]  fifo_level,
    output logic [7:0]  drop_count,
    output logic [7:0]  clip_count
`ifdef CLEAR_SCREEN_EN
    ,
    input  logic        clear_req,
    output logic        clear_done
`endif
);

    localparam int         PTR_W      = $clog2(FIFO_DEPTH);
    localparam logic [2:0] LEVEL_FULL = 3'(FIFO_DEPTH);
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WRITE   = 2'd1;
`ifdef CLEAR_SCREEN_EN
    localparam logic [1:0]  ST_CLEAR  = 2'd2;
    localparam logic [14:0] LAST_ADDR = 15'(SCREEN_W * SCREEN_H - 1);
`endif

    logic [17:0]      r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [2:0]       r_level;
    logic [1:0]       r_state;
    logic [14:0]      r_addr;
    logic [2:0]       r_data;
    logic [7:0]       r_drop;
    logic [7:0]       r_clip;

    logic [17:0] w_head;
    logic [7:0]  w_hx;
    logic [6:0]  w_hy;
    logic [2:0]  w_hc;
    logic        w_clearing;
    logic        w_start_clear;
    logic        w_push;
    logic        w_pop;
    logic        w_offscreen;
    logic        w_load;
    logic        w_write_done;
    logic [14:0] w_addr;

    assign w_head = r_fifo[r_rd_ptr];
    assign w_hx   = w_head[17:10];
    assign w_hy   = w_head[9:3];
    assign w_hc   = w_head[2:0];

`ifdef CLEAR_SCREEN_EN
    assign w_clearing    = (r_state == ST_CLEAR);
    assign w_start_clear = (r_state == ST_IDLE) && clear_req;
`else
    assign w_clearing    = 1'b0;
    assign w_start_clear = 1'b0;
`endif

    // Full check uses only the registered level, so a same-cycle pop never frees a slot.
    assign ready_out    = (r_level != LEVEL_FULL) && !w_clearing;
    assign w_push       = plot_in && ready_out;
    assign w_write_done = (r_state == ST_WRITE) && !mem_busy;
    assign w_pop        = (r_level != 3'd0) &&
                          (((r_state == ST_IDLE) && !w_start_clear) || w_write_done);
    assign w_offscreen  = (w_hx >= 8'(SCREEN_W)) || (w_hy >= 7'(SCREEN_H));
    assign w_load       = w_pop && !w_offscreen;
    assign w_addr       = 15'({w_hy, 7'b0}) + 15'({w_hy, 5'b0}) + 15'(w_hx);

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= {x_in, y_in, colour_in};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= 3'd0;
            r_drop   <= 8'd0;
            r_clip   <= 8'd0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 3'd1;
                2'b01:   r_level <= r_level - 3'd1;
                default: r_level <= r_level;
            endcase
            if (plot_in && !ready_out && (r_drop != 8'hFF)) r_drop <= r_drop + 8'd1;
            if (w_pop && w_offscreen && (r_clip != 8'hFF)) r_clip <= r_clip + 8'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_addr  <= 15'd0;
            r_data  <= 3'd0;
        end else begin
            case (r_state)
                ST_IDLE, ST_WRITE: begin
`ifdef CLEAR_SCREEN_EN
                    if (w_start_clear) begin
                        r_state <= ST_CLEAR;
                        r_addr  <= 15'd0;
                        r_data  <= CLEAR_COLOUR;
                    end else
`endif
                    if (w_load) begin
                        r_state <= ST_WRITE;
                        r_addr  <= w_addr;
                        r_data  <= w_hc;
                    end else if (w_write_done) begin
                        r_state <= ST_IDLE;
                    end
                end
`ifdef CLEAR_SCREEN_EN
                ST_CLEAR: begin
                    if (!mem_busy) begin
                        if (r_addr == LAST_ADDR) r_state <= ST_IDLE;
                        else                     r_addr  <= r_addr + 15'd1;
                    end
                end
`endif
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef CLEAR_SCREEN_EN
    logic r_clear_done;

    always_ff @(posedge clock) begin
        if (reset) r_clear_done <= 1'b0;
        else       r_clear_done <= w_clearing && !mem_busy && (r_addr == LAST_ADDR);
    end

    assign clear_done = r_clear_done;
`endif

    assign mem_we     = (r_state != ST_IDLE);
    assign mem_addr   = r_addr;
    assign mem_data   = r_data;
    assign fifo_level = r_level;
    assign drop_count = r_drop;
    assign clip_count = r_clip;

endmodule
